// File: rtl/sb_cfg_pkg.sv
// Shared select codes, commit FSM states and address-width helper for the corner switch block.
package sb_cfg_pkg;

  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_IN0  = 2'b01;
  localparam logic [1:0] SEL_IN1  = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  typedef enum logic {
    StIdle,
    StCommit
  } state_e;

  // Config address width needed to index all 2*chan_w muxes.
  function automatic int unsigned addr_w(input int unsigned chan_w);
    return $clog2(2 * chan_w);
  endfunction

endpackage

// File: rtl/sb_route_mux2.sv
// Two-input routing mux with 2-bit select and an optional output flop.
module sb_route_mux2
  import sb_cfg_pkg::*;
#(
  parameter bit RegOut = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] sel_i,
  input  logic       in0_i,
  input  logic       in1_i,
  output logic       out_o
);

  logic mux_d;
  logic mux_q;

  // Decode the select; the reserved code drives 0 like SEL_ZERO.
  always_comb begin
    mux_d = 1'b0;
    case (sel_i)
      SEL_IN0:            mux_d = in0_i;
      SEL_IN1:            mux_d = in1_i;
      SEL_ZERO, SEL_RSVD: mux_d = 1'b0;
      default:            mux_d = 1'b0;
    endcase
  end

  // Output stage; left unused (and trimmed) when RegOut is 0.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mux_q <= 1'b0;
    end else begin
      mux_q <= mux_d;
    end
  end

  assign out_o = RegOut ? mux_q : mux_d;

endmodule

// File: rtl/sb_shadow_cfg_xbar.sv
// Corner switch block: double-buffered mux selects with a one-entry-per-cycle commit walk.
module sb_shadow_cfg_xbar
  import sb_cfg_pkg::*;
#(
  parameter int unsigned CHAN_W  = 9,
  parameter int unsigned REG_OUT = 0,
  localparam int unsigned ADDR_W = addr_w(CHAN_W)
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic [CHAN_W-1:0] chany_bottom_in,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] bottom_grid_pin,
  input  logic [CHAN_W-1:0] left_grid_pin,
  input  logic              cfg_wr_en,
  input  logic              cfg_rd_en,
  input  logic              cfg_rd_sel,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [1:0]        cfg_wdata,
  input  logic              cfg_commit,
  output logic [1:0]        cfg_rdata,
  output logic              cfg_rvalid,
  output logic              cfg_busy,
  output logic              cfg_err,
  output logic [CHAN_W-1:0] chany_bottom_out,
  output logic [CHAN_W-1:0] chanx_left_out
);

  localparam int unsigned       N       = 2 * CHAN_W;
  localparam logic [ADDR_W:0]   NumMux  = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        shadow_q [N];
  logic [1:0]        active_q [N];
  logic [1:0]        rdata_q, rdata_d;
  logic              rvalid_q;
  logic              err_q, err_d;

  logic busy;
  logic addr_ok;
  logic wr_ok;

  assign busy    = (state_q == StCommit);
  // Extra MSB keeps the compare correct when N is a power of two.
  assign addr_ok = ({1'b0, cfg_addr} < NumMux);
  assign wr_ok   = cfg_wr_en && !busy && addr_ok;

  // Commit walk sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_commit) begin
          state_d = StCommit;
          idx_d   = '0;
        end
      end
      StCommit: begin
        idx_d = idx_q + ADDR_W'(1);
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // Read data (pre-write value) and combined error flag for this cycle's requests.
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_rd_en) begin
      if (!addr_ok) begin
        rdata_d = SEL_ZERO;
      end else if (cfg_rd_sel) begin
        rdata_d = active_q[cfg_addr];
      end else begin
        rdata_d = shadow_q[cfg_addr];
      end
    end
    err_d = (cfg_wr_en && (busy || !addr_ok)) ||
            (cfg_commit && busy) ||
            (cfg_rd_en && !addr_ok);
  end

  // FSM and read-port registers.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      rdata_q  <= SEL_ZERO;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= cfg_rd_en;
      err_q    <= err_d;
    end
  end

  // Shadow writes in idle; active array takes one shadow entry per walk cycle.
  always_ff @(posedge prog_clk) begin
    if (!prog_rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        shadow_q[k] <= SEL_ZERO;
        active_q[k] <= SEL_ZERO;
      end
    end else begin
      if (wr_ok) begin
        shadow_q[cfg_addr] <= cfg_wdata;
      end
      if (busy) begin
        active_q[idx_q] <= shadow_q[idx_q];
      end
    end
  end

  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;
  assign cfg_busy   = busy;
  assign cfg_err    = err_q;

  for (genvar i = 0; i < CHAN_W; i++) begin : g_track
    sb_route_mux2 #(
      .RegOut (REG_OUT != 0)
    ) u_bottom_mux (
      .clk_i  (prog_clk),
      .rst_ni (prog_rst_n),
      .sel_i  (active_q[i]),
      .in0_i  (bottom_grid_pin[i]),
      .in1_i  (chanx_left_in[(i + 1) % CHAN_W]),
      .out_o  (chany_bottom_out[i])
    );

    sb_route_mux2 #(
      .RegOut (REG_OUT != 0)
    ) u_left_mux (
      .clk_i  (prog_clk),
      .rst_ni (prog_rst_n),
      .sel_i  (active_q[CHAN_W + i]),
      .in0_i  (chany_bottom_in[(i + CHAN_W - 1) % CHAN_W]),
      .in1_i  (left_grid_pin[i]),
      .out_o  (chanx_left_out[i])
    );
  end

endmodule

// File: tb/tb_sb_shadow_cfg_xbar.sv
// Bench for sb_shadow_cfg_xbar: vector table, commit-walk sequences and a random run
// checked against a behavioural model, on a combinational and a registered-output instance.
module tb_sb_shadow_cfg_xbar;

  localparam int CW = 9;
  localparam int NM = 2 * CW;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] chany_bottom_in, chanx_left_in, bottom_grid_pin, left_grid_pin;
  logic          cfg_wr_en, cfg_rd_en, cfg_rd_sel, cfg_commit;
  logic [4:0]    cfg_addr;
  logic [1:0]    cfg_wdata;
  logic [1:0]    cfg_rdata, r1_rdata;
  logic          cfg_rvalid, cfg_busy, cfg_err, r1_rvalid, r1_busy, r1_err;
  logic [CW-1:0] chany_bottom_out, chanx_left_out, r1_bottom_out, r1_left_out;

  int n_cmp  = 0;
  int n_fail = 0;

  sb_shadow_cfg_xbar #(.CHAN_W(CW), .REG_OUT(0)) u_dut (
    .prog_clk(clk), .prog_rst_n(rst_n),
    .chany_bottom_in(chany_bottom_in), .chanx_left_in(chanx_left_in),
    .bottom_grid_pin(bottom_grid_pin), .left_grid_pin(left_grid_pin),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_rd_sel(cfg_rd_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .chany_bottom_out(chany_bottom_out), .chanx_left_out(chanx_left_out)
  );

  sb_shadow_cfg_xbar #(.CHAN_W(CW), .REG_OUT(1)) u_dut_reg (
    .prog_clk(clk), .prog_rst_n(rst_n),
    .chany_bottom_in(chany_bottom_in), .chanx_left_in(chanx_left_in),
    .bottom_grid_pin(bottom_grid_pin), .left_grid_pin(left_grid_pin),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_rd_sel(cfg_rd_sel),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit),
    .cfg_rdata(r1_rdata), .cfg_rvalid(r1_rvalid), .cfg_busy(r1_busy), .cfg_err(r1_err),
    .chany_bottom_out(r1_bottom_out), .chanx_left_out(r1_left_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: shadow/active arrays and walk position (-1 when idle).
  logic [1:0] m_sh [NM];
  logic [1:0] m_ac [NM];
  int         m_walk;
  logic [1:0] m_rdata;
  logic       m_rvalid, m_err;
  bit         hold_pins;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pick(input logic [1:0] sel, input logic a, input logic b);
    if (sel == 2'b01) return a;
    if (sel == 2'b10) return b;
    return 1'b0;
  endfunction

  task automatic route(output logic [CW-1:0] b, output logic [CW-1:0] l);
    for (int i = 0; i < CW; i++) begin
      b[i] = pick(m_ac[i], bottom_grid_pin[i], chanx_left_in[(i + 1) % CW]);
      l[i] = pick(m_ac[CW + i], chany_bottom_in[(i + CW - 1) % CW], left_grid_pin[i]);
    end
  endtask

  task automatic model_edge();
    bit busy, in_rng;
    if (!rst_n) begin
      for (int k = 0; k < NM; k++) begin
        m_sh[k] = 2'b00;
        m_ac[k] = 2'b00;
      end
      m_walk = -1; m_rdata = 2'b00; m_rvalid = 1'b0; m_err = 1'b0;
    end else begin
      busy   = (m_walk >= 0);
      in_rng = (int'(cfg_addr) < NM);
      m_err  = (cfg_wr_en && (busy || !in_rng)) || (cfg_commit && busy) || (cfg_rd_en && !in_rng);
      m_rvalid = cfg_rd_en;
      if (cfg_rd_en) m_rdata = !in_rng ? 2'b00 : (cfg_rd_sel ? m_ac[cfg_addr] : m_sh[cfg_addr]);
      if (busy) begin
        m_ac[m_walk] = m_sh[m_walk];
        m_walk++;
        if (m_walk == NM) m_walk = -1;
      end else begin
        if (cfg_wr_en && in_rng) m_sh[cfg_addr] = cfg_wdata;
        if (cfg_commit) m_walk = 0;
      end
    end
  endtask

  // One clock: model update at the edge, compare 1 time unit later, return at the negedge.
  task automatic step();
    logic [CW-1:0] pre_b, pre_l, exp_b, exp_l;
    bit            in_rst;
    route(pre_b, pre_l);
    in_rst = !rst_n;
    @(posedge clk);
    model_edge();
    #1;
    route(exp_b, exp_l);
    chk("busy", cfg_busy, m_walk >= 0);
    chk("err", cfg_err, m_err);
    chk("rvalid", cfg_rvalid, m_rvalid);
    chk("rdata", cfg_rdata, m_rdata);
    chk("bottom_out", chany_bottom_out, exp_b);
    chk("left_out", chanx_left_out, exp_l);
    chk("reg_bottom_out", r1_bottom_out, in_rst ? '0 : pre_b);
    chk("reg_left_out", r1_left_out, in_rst ? '0 : pre_l);
    @(negedge clk);
  endtask

  task automatic idle_in();
    cfg_wr_en = 1'b0; cfg_rd_en = 1'b0; cfg_rd_sel = 1'b0; cfg_commit = 1'b0;
    cfg_addr = 5'd0; cfg_wdata = 2'b00;
    chany_bottom_in = CW'($urandom); chanx_left_in = CW'($urandom);
    bottom_grid_pin = CW'($urandom); left_grid_pin = CW'($urandom);
    if (hold_pins) begin
      bottom_grid_pin    = '1;
      chany_bottom_in[8] = 1'b1;
    end
  endtask

  task automatic read_all(input logic sel, input logic [1:0] exp, input string name);
    for (int a = 0; a < NM; a++) begin
      idle_in();
      cfg_rd_en = 1'b1; cfg_rd_sel = sel; cfg_addr = 5'(a);
      step();
      chk(name, cfg_rdata, exp);
    end
  endtask

  typedef struct {
    logic       wr, rd, sel;
    logic [4:0] addr;
    logic [1:0] wdata;
    logic       e_err, e_rvalid;
    logic [1:0] e_rdata;
  } vec_t;

  vec_t vecs [11];
  int   busy_cycles;

  initial begin
    hold_pins = 1'b0;
    rst_n = 1'b0;
    idle_in();
    m_walk = -1;
    @(negedge clk);
    step();
    step();
    chk("rst_busy", cfg_busy, 0);
    chk("rst_rvalid", cfg_rvalid, 0);
    chk("rst_bottom", chany_bottom_out, 0);
    rst_n = 1'b1;

    // Fill shadow with 01; outputs must not move.
    for (int a = 0; a < NM; a++) begin
      idle_in();
      cfg_wr_en = 1'b1; cfg_addr = 5'(a); cfg_wdata = 2'b01;
      step();
      chk("no_commit_bottom", chany_bottom_out, 0);
      chk("no_commit_left", chanx_left_out, 0);
    end
    read_all(1'b0, 2'b01, "rd_shadow_01");
    read_all(1'b1, 2'b00, "rd_active_00");

    //            wr    rd    sel   addr   wdata  err   rvalid rdata
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd18, 2'b10, 1'b1, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd31, 2'b00, 1'b1, 1'b1, 2'b00};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd5,  2'b00, 1'b0, 1'b1, 2'b01};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'd4,  2'b10, 1'b0, 1'b1, 2'b01};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'd4,  2'b00, 1'b0, 1'b1, 2'b10};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 5'd5,  2'b11, 1'b0, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'd5,  2'b00, 1'b0, 1'b1, 2'b11};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 5'd5,  2'b00, 1'b0, 1'b1, 2'b00};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 5'd17, 2'b10, 1'b0, 1'b1, 2'b01};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0,  2'b00, 1'b0, 1'b0, 2'b00};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd18, 2'b00, 1'b1, 1'b1, 2'b00};
    for (int v = 0; v < 11; v++) begin
      idle_in();
      cfg_wr_en = vecs[v].wr; cfg_rd_en = vecs[v].rd; cfg_rd_sel = vecs[v].sel;
      cfg_addr = vecs[v].addr; cfg_wdata = vecs[v].wdata;
      step();
      chk($sformatf("vec%0d_err", v), cfg_err, vecs[v].e_err);
      chk($sformatf("vec%0d_rvalid", v), cfg_rvalid, vecs[v].e_rvalid);
      if (vecs[v].e_rvalid) chk($sformatf("vec%0d_rdata", v), cfg_rdata, vecs[v].e_rdata);
    end

    // Commit with a same-cycle write to entry 0; rejected write/commit during the walk.
    hold_pins = 1'b1;
    idle_in();
    cfg_commit = 1'b1; cfg_wr_en = 1'b1; cfg_addr = 5'd0; cfg_wdata = 2'b10;
    step();
    chk("busy_start", cfg_busy, 1);
    busy_cycles = cfg_busy ? 1 : 0;
    for (int j = 1; j <= 40 && cfg_busy; j++) begin
      idle_in();
      if (j == 5) begin cfg_wr_en = 1'b1; cfg_addr = 5'd2; cfg_wdata = 2'b11; end
      if (j == 7) cfg_commit = 1'b1;
      step();
      if (cfg_busy) busy_cycles++;
      if (j == 3)  chk("b3_before", chany_bottom_out[3], 0);
      if (j == 4)  chk("b3_after", chany_bottom_out[3], bottom_grid_pin[3]);
      if (j == 5)  chk("err_busy_wr", cfg_err, 1);
      if (j == 6)  chk("err_pulse", cfg_err, 0);
      if (j == 7)  chk("err_busy_commit", cfg_err, 1);
      if (j == 9)  chk("l0_before", chanx_left_out[0], 0);
      if (j == 10) chk("l0_after", chanx_left_out[0], chany_bottom_in[8]);
    end
    chk("busy_cycles", busy_cycles, NM);
    chk("rsvd_zero", chany_bottom_out[5], 0);
    chk("wr_with_commit", chany_bottom_out[0], chanx_left_in[1]);
    chk("entry4_in1", chany_bottom_out[4], chanx_left_in[5]);

    // Back-to-back commit right after busy falls.
    idle_in();
    cfg_commit = 1'b1;
    step();
    chk("b2b_accept", cfg_busy, 1);
    chk("b2b_no_err", cfg_err, 0);
    for (int j = 0; j < 40 && cfg_busy; j++) begin
      idle_in();
      step();
    end
    chk("b2b_done", cfg_busy, 0);
    idle_in();
    cfg_rd_en = 1'b1; cfg_addr = 5'd2;
    step();
    chk("shadow2_kept", cfg_rdata, 2'b01);
    hold_pins = 1'b0;

    // Reset during walk cycle 7 aborts the walk and clears both arrays.
    idle_in();
    cfg_commit = 1'b1;
    step();
    for (int j = 1; j < 7; j++) begin
      idle_in();
      step();
    end
    chk("walk_running", cfg_busy, 1);
    idle_in();
    rst_n = 1'b0;
    step();
    chk("abort_busy", cfg_busy, 0);
    chk("abort_bottom", chany_bottom_out, 0);
    chk("abort_left", chanx_left_out, 0);
    rst_n = 1'b1;
    read_all(1'b0, 2'b00, "abort_shadow");
    read_all(1'b1, 2'b00, "abort_active");

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      idle_in();
      cfg_wr_en  = ($urandom_range(0, 9) < 4);
      cfg_rd_en  = ($urandom_range(0, 9) < 4);
      cfg_rd_sel = 1'($urandom);
      cfg_addr   = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, NM - 1)) : 5'($urandom);
      cfg_wdata  = 2'($urandom);
      cfg_commit = ($urandom_range(0, 29) == 0);
      rst_n      = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sb_shadow_cfg_xbar.md
# sb_shadow_cfg_xbar

Parametrised switch block for the corner tiles with CHAN_W tracks per side and two-input routing muxes, one per output track. Mux selects are double-buffered: the configuration port writes a shadow array, and a commit sequence copies it into the active array one entry per cycle. The block adds a per-mux disable code, readback of either array, error flagging and optional registered outputs. It sits between the bottom and left routing channels and the adjacent grid output pins, on the programming clock domain.

## Interface
- CHAN_W, 9: tracks per side; number of muxes N = 2*CHAN_W.
- REG_OUT, 0: 0 = combinational track outputs; 1 = one flop stage on every track output.
- ADDR_W, derived as clog2(2*CHAN_W), 5 at default: width of the config address.

Ports:
- prog_clk  in  1  sole clock
- prog_rst_n  in  1  synchronous, active-low reset
- chany_bottom_in  in  CHAN_W  bottom channel incoming tracks
- chanx_left_in  in  CHAN_W  left channel incoming tracks
- bottom_grid_pin  in  CHAN_W  grid pins feeding bottom tracks
- left_grid_pin  in  CHAN_W  grid pins feeding left tracks
- cfg_wr_en  in  1  write cfg_wdata to shadow[cfg_addr]
- cfg_rd_en  in  1  read request
- cfg_rd_sel  in  1  0 = read shadow, 1 = read active
- cfg_addr  in  ADDR_W  entry index; 0..CHAN_W-1 are bottom tracks, CHAN_W..N-1 are left tracks
- cfg_wdata  in  2  select code
- cfg_commit  in  1  start shadow-to-active copy
- cfg_rdata  out  2  read data
- cfg_rvalid  out  1  read data valid, one-cycle pulse
- cfg_busy  out  1  commit walk in progress
- cfg_err  out  1  one-cycle pulse flagging a rejected request
- chany_bottom_out  out  CHAN_W  bottom channel outgoing tracks
- chanx_left_out  out  CHAN_W  left channel outgoing tracks

## Operation
- Select code: 00 = output driven 0; 01 = input 0; 10 = input 1; 11 = reserved, behaves as 00.
- Bottom track i: input 0 is bottom_grid_pin[i]; input 1 is chanx_left_in[(i+1) mod CHAN_W].
- Left track i: input 0 is chany_bottom_in[(i+CHAN_W-1) mod CHAN_W]; input 1 is left_grid_pin[i].
- Track outputs are driven only by the active array. Shadow writes never change the outputs directly.

State machine IDLE/COMMIT, with counter idx of width ADDR_W:
- IDLE and cfg_commit: go to COMMIT with idx = 0.
- COMMIT: each cycle, active[idx] <= shadow[idx] and idx increments. After idx = N-1, return to IDLE.
- cfg_busy = (state == COMMIT).

Writes:
- Accepted in IDLE only.
- A write while busy is dropped and pulses cfg_err.
- cfg_addr >= N: write dropped, cfg_err pulses.

Reads:
- Allowed in any state. cfg_rdata is registered; cfg_rvalid follows cfg_rd_en by one cycle.
- cfg_addr >= N: cfg_rdata = 00, cfg_rvalid = 1, cfg_err pulses.
- Read and write to the same address in the same cycle: the read returns the pre-write value.
- cfg_commit while busy: ignored, cfg_err pulses.
- Write and commit in the same IDLE cycle: the write lands and is included in the commit.
- cfg_err is the OR of all error conditions in a cycle; it is a single pulse.

## Timing
- Reset values: shadow and active arrays all 00; all track outputs 0; cfg_busy, cfg_err, cfg_rvalid and cfg_rdata all 0; state IDLE.
- Reset mid-commit: walk is aborted and both arrays clear.
- Commit accepted at edge t: cfg_busy is high for cycles t+1 .. t+N. Entry k reaches the active array at edge t+1+k.
- During the walk, entries below idx use new selects and the rest use old ones; partial states are visible on the outputs.
- Write accepted at edge t: visible on read from cycle t+1.
- Track path: combinational from inputs and active array when REG_OUT = 0; one-cycle latency when REG_OUT = 1.
- Back-to-back commits: a commit in the cycle after cfg_busy falls is accepted.

## Structure
- Package sb_cfg_pkg: select-code localparams (SEL_ZERO, SEL_IN0, SEL_IN1, SEL_RSVD), state enum (IDLE, COMMIT), and clog2-based ADDR_W helper.
- Sub-module sb_route_mux2: decodes a 2-bit select over two inputs with optional output flop. It is instantiated N times.
- Top level contains the shadow/active arrays, the FSM and the read/write port.

## Test plan
- Reset, then write 01 to all 18 entries without committing -> all outputs stay 0; readback with cfg_rd_sel = 0 returns 01 and with cfg_rd_sel = 1 returns 00.
- Commit with CHAN_W = 9 -> cfg_busy high for 18 cycles; chany_bottom_out[3] follows bottom_grid_pin[3] from the cycle after edge t+4; chanx_left_out[0] follows chany_bottom_in[8] once entry 9 lands.
- During busy, write addr 2 and issue cfg_commit -> both rejected, cfg_err pulses each time, shadow[2] unchanged.
- Write to addr 18 and read addr 31 -> cfg_err pulses; read returns 00 with cfg_rvalid = 1.
- Write code 11 to entry 5 and commit -> chany_bottom_out[5] = 0. Also with REG_OUT = 1 -> each output lags its input by exactly one cycle.
- Assert prog_rst_n low at walk cycle 7 -> cfg_busy falls, all outputs and both arrays read 00.
